// File: rtl/bus_led_segment_io.sv
`default_nettype none
// ============================================================================
// bus_led_segment_io : bus-mapped LED/seven-segment/switch I/O responder
// Revision: 1.0  initial release
// ============================================================================
module bus_led_segment_io #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        bus_cs,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic [2:0]  SW,
  output logic [7:0]  led_data,
  output logic [7:0]  segment_data,
  output logic [3:0]  AN
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [15:0]      seg_val;
  logic [7:0]       seg_ctl;
  logic [2:0]       sw_s1;
  logic [2:0]       sw_sync;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx;
  logic [3:0]       nibble;
  logic             unused_wdata;

  assign unused_wdata = ^bus_wdata[31:16];

  function automatic logic [6:0] hex7n(input logic [3:0] v);
    case (v)
      4'h0: hex7n = 7'h40;
      4'h1: hex7n = 7'h79;
      4'h2: hex7n = 7'h24;
      4'h3: hex7n = 7'h30;
      4'h4: hex7n = 7'h19;
      4'h5: hex7n = 7'h12;
      4'h6: hex7n = 7'h02;
      4'h7: hex7n = 7'h78;
      4'h8: hex7n = 7'h00;
      4'h9: hex7n = 7'h10;
      4'hA: hex7n = 7'h08;
      4'hB: hex7n = 7'h03;
      4'hC: hex7n = 7'h46;
      4'hD: hex7n = 7'h21;
      4'hE: hex7n = 7'h06;
      default: hex7n = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_next;
  end

  // Requests seen while responding are dropped, not queued.
  always_comb begin
    state_next = state;
    bus_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus_cs) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        bus_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      led_data  <= 8'h00;
      seg_val   <= 16'h0000;
      seg_ctl   <= 8'h00;
      bus_rdata <= 32'h0;
    end else if (accept) begin
      if (bus_we) begin
        case (bus_addr)
          2'd0:    led_data <= bus_wdata[7:0];
          2'd1:    seg_val  <= bus_wdata[15:0];
          2'd2:    seg_ctl  <= bus_wdata[7:0];
          default: ;
        endcase
      end else begin
        case (bus_addr)
          2'd0:    bus_rdata <= {24'h0, led_data};
          2'd1:    bus_rdata <= {16'h0, seg_val};
          2'd2:    bus_rdata <= {24'h0, seg_ctl};
          default: bus_rdata <= {29'h0, sw_sync};
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sw_s1   <= 3'b000;
      sw_sync <= 3'b000;
    end else begin
      sw_s1   <= SW;
      sw_sync <= sw_s1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nibble = seg_val[3:0];
    case (idx)
      2'd0:    nibble = seg_val[3:0];
      2'd1:    nibble = seg_val[7:4];
      2'd2:    nibble = seg_val[11:8];
      default: nibble = seg_val[15:12];
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      AN           <= 4'hF;
      segment_data <= 8'hFF;
    end else begin
      AN           <= seg_ctl[{1'b0, idx}] ? 4'hF : ~(4'b0001 << idx);
      segment_data <= {~seg_ctl[{1'b1, idx}], hex7n(nibble)};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_led_segment_io.sv
`default_nettype none
// ============================================================================
// tb_bus_led_segment_io : directed self-checking bench for bus_led_segment_io
// Revision: 1.0  initial release
// ============================================================================
module tb_bus_led_segment_io;

  logic        clk = 1'b0;
  logic        res;
  logic        bus_cs;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [2:0]  SW;
  logic [7:0]  led_data;
  logic [7:0]  segment_data;
  logic [3:0]  AN;

  int checks = 0;
  int errors = 0;

  bus_led_segment_io #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .res          (res),
    .bus_cs       (bus_cs),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready),
    .SW           (SW),
    .led_data     (led_data),
    .segment_data (segment_data),
    .AN           (AN)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_cs    = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    cyc();
    check("wr_ready", {31'b0, bus_ready}, 32'd1);
    bus_cs = 1'b0;
    bus_we = 1'b0;
    cyc();
  endtask

  logic [3:0] scan_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] scan_seg [4] = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
  logic [3:0] blank_an [4] = '{4'hD, 4'hF, 4'h7, 4'hF};
  logic       found;
  logic [3:0] prev_an;
  int         pulses;

  initial begin
    res = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 2'd0;
    bus_wdata = 32'h0; SW = 3'b000;

    // Reset
    repeat (10) cyc();
    check("rst_led",   led_data,     32'h00);
    check("rst_an",    AN,           32'hF);
    check("rst_seg",   segment_data, 32'hFF);
    check("rst_ready", bus_ready,    32'd0);
    check("rst_rdata", bus_rdata,    32'h0);
    res = 1'b0;
    cyc();
    check("first_an",  AN,           32'hE);
    check("first_seg", segment_data, 32'hC0);

    // LED write then read
    bus_cs = 1'b1; bus_we = 1'b1; bus_addr = 2'd0; bus_wdata = 32'h1A5;
    cyc();
    check("led_wr_val",   led_data,  32'hA5);
    check("led_wr_ready", bus_ready, 32'd1);
    bus_cs = 1'b0; bus_we = 1'b0;
    cyc();
    check("led_wr_ready_off", bus_ready, 32'd0);
    bus_cs = 1'b1; bus_addr = 2'd0;
    cyc();
    check("led_rd_ready", bus_ready, 32'd1);
    check("led_rd_data",  bus_rdata, 32'h000000A5);
    bus_cs = 1'b0;
    cyc();
    check("led_rd_ready_off", bus_ready, 32'd0);
    check("led_rd_hold",      bus_rdata, 32'h000000A5);

    // Display scan
    bus_write(2'd1, 32'h1234);
    bus_write(2'd2, 32'h10);
    bus_cs = 1'b1; bus_addr = 2'd1;
    cyc();
    check("segval_rd", bus_rdata, 32'h1234);
    bus_cs = 1'b0;
    cyc();
    found = 1'b0;
    prev_an = AN;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (AN == 4'hE && prev_an != 4'hE) found = 1'b1;
      else prev_an = AN;
    end
    check("scan_sync", {31'b0, found}, 32'd1);
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        check("scan_an",  AN,           scan_an[s % 4]);
        check("scan_seg", segment_data, scan_seg[s % 4]);
        cyc();
      end
    end

    // Blanking
    bus_write(2'd2, 32'h05);
    found = 1'b0;
    prev_an = AN;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (AN == 4'hD && prev_an != 4'hD) found = 1'b1;
      else prev_an = AN;
    end
    check("blank_sync", {31'b0, found}, 32'd1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        check("blank_an", AN, blank_an[s]);
        cyc();
      end
    end

    // Switch read latency
    SW = 3'b101;
    cyc();
    bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 2'd3;
    cyc();
    check("sw_rd_early_ready", bus_ready, 32'd1);
    check("sw_rd_early",       bus_rdata, 32'h0);
    bus_cs = 1'b0;
    cyc();
    cyc();
    bus_cs = 1'b1;
    cyc();
    check("sw_rd_late", bus_rdata, 32'h5);
    bus_cs = 1'b0;
    cyc();

    // Write to SW is dropped but completes
    bus_write(2'd3, 32'h2);
    bus_cs = 1'b1; bus_addr = 2'd3;
    cyc();
    check("sw_wr_dropped", bus_rdata, 32'h5);
    bus_cs = 1'b0;
    cyc();

    // Back-to-back with bus_cs held high
    bus_cs = 1'b1; bus_we = 1'b1; bus_addr = 2'd0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      bus_wdata = 32'h10 + k;
      cyc();
      check("b2b_ready", {31'b0, bus_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (bus_ready) pulses++;
    end
    bus_cs = 1'b0; bus_we = 1'b0;
    check("b2b_pulses", pulses,   32'd3);
    check("b2b_led",    led_data, 32'h14);
    cyc();

    // Reset during RESP
    bus_cs = 1'b1; bus_we = 1'b1; bus_wdata = 32'h77;
    cyc();
    check("rsp_ready", bus_ready, 32'd1);
    bus_cs = 1'b0; bus_we = 1'b0;
    res = 1'b1;
    #1;
    check("rsp_rst_ready", bus_ready, 32'd0);
    check("rsp_rst_an",    AN,        32'hF);
    check("rsp_rst_led",   led_data,  32'h00);
    cyc();
    check("rsp_rst_hold_ready", bus_ready, 32'd0);
    res = 1'b0;
    cyc();
    check("restart_an",    AN,           32'hE);
    check("restart_seg",   segment_data, 32'hC0);
    check("restart_ready", bus_ready,    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
